// File: rtl/pico_mem_mpu.sv
// Word-granular MPU between the picorv32 memory port and a synchronous SRAM.
// Define MPU_VIOLATION_IRQ_EN to drive the violation interrupt pulse.
module pico_mem_mpu #(
    parameter int DATA_WIDTH     = 32,
    parameter int MPU_START_ADDR = 768
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  is_inst,
    input  logic [31:0]           pc_addr,
    output logic                  inform_cpu_wait,
    output logic                  interrupt,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic [21:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [3:0]            cpu_wstrb,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [3:0]            mem_wen,
    output logic [21:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_RESP
    } state_e;

    localparam logic [21:0] C_LO = 22'(MPU_START_ADDR);
    localparam logic [21:0] C_HI = 22'(MPU_START_ADDR + 5);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        allow_q, allow_d;
    logic [31:0] cfg_q [5];
    logic [31:0] cfg_d [5];

    logic        in_d, in_t, in_c, allow;
    logic [21:0] dlo, dhi, c_rel;
    logic [2:0]  c_off;

    always_comb begin
        dlo   = cfg_q[1][21:0];
        dhi   = cfg_q[2][21:0];
        c_rel = cpu_addr - C_LO;
        c_off = c_rel[2:0];
        in_d  = (dlo < dhi) && (cpu_addr >= dlo) && (cpu_addr < dhi);
        in_t  = (cfg_q[3] < cfg_q[4]) && (pc_addr >= cfg_q[3])
                && (pc_addr < cfg_q[4]);
        in_c  = (cpu_addr >= C_LO) && (cpu_addr < C_HI);
        if (!cfg_q[0][0])
            allow = 1'b1;
        else if (is_inst)
            allow = !in_d;
        else
            allow = in_t || !(in_d || in_c);
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        allow_d         = allow_q;
        cfg_d           = cfg_q;
        inform_cpu_wait = 1'b0;
        interrupt       = 1'b0;
        cpu_ready       = 1'b0;
        cpu_rdata       = '0;
        mem_wen         = 4'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        unique case (state_q)
            S_LOAD: begin
                inform_cpu_wait = 1'b1;
                // address held at 0 while reset is asserted
                if (resetn && cnt_q < 3'd5)
                    mem_addr = C_LO + 22'(cnt_q);
                if (cnt_q != 3'd0)
                    cfg_d[cnt_q - 3'd1] = mem_rdata;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cpu_valid) begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    mem_wen   = allow ? cpu_wstrb : 4'b0;
                    allow_d   = allow;
                    state_d   = S_RESP;
                    if (allow && in_c) begin
                        for (int b = 0; b < 4; b++)
                            if (cpu_wstrb[b])
                                cfg_d[c_off][8*b +: 8] = cpu_wdata[8*b +: 8];
                    end
                end
            end
            S_RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = allow_q ? mem_rdata : '0;
`ifdef MPU_VIOLATION_IRQ_EN
                interrupt = !allow_q;
`endif
                state_d   = S_IDLE;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_LOAD;
            cnt_q   <= 3'd0;
            allow_q <= 1'b0;
            for (int i = 0; i < 5; i++)
                cfg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            allow_q <= allow_d;
            cfg_q   <= cfg_d;
        end
    end

endmodule

// File: tb/tb_pico_mem_mpu.sv
// Directed bench for pico_mem_mpu with a one-cycle-latency SRAM model.
module tb_pico_mem_mpu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        is_inst;
    logic [31:0] pc_addr;
    logic        inform_cpu_wait;
    logic        interrupt;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [21:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic [3:0]  mem_wen;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [1024];

`ifdef MPU_VIOLATION_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    int pass_n  = 0;
    int total_n = 0;

    always #5 clk = ~clk;

    pico_mem_mpu #(.DATA_WIDTH(32), .MPU_START_ADDR(768)) dut (
        .clk(clk), .resetn(resetn), .is_inst(is_inst), .pc_addr(pc_addr),
        .inform_cpu_wait(inform_cpu_wait), .interrupt(interrupt),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wen[b] && mem_addr[21:10] == 12'd0)
                mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_load(output int n, output logic wen_seen);
        n = 0;
        wen_seen = 1'b0;
        while (inform_cpu_wait && n < 20) begin
            if (mem_wen != 4'b0) wen_seen = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic xfer(input logic [21:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic inst,
                        input logic [31:0] pc,
                        output logic [3:0] wen, output logic rdy0,
                        output logic rdy, output logic [31:0] rd,
                        output logic irq, output logic irq_after);
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wstrb = st;
        is_inst   = inst;
        pc_addr   = pc;
        #1;
        wen  = mem_wen;
        rdy0 = cpu_ready;
        @(posedge clk);
        #1;
        rdy = cpu_ready;
        rd  = cpu_rdata;
        irq = interrupt;
        @(negedge clk);
        cpu_valid = 1'b0;
        cpu_wstrb = 4'b0;
        is_inst   = 1'b0;
        @(posedge clk);
        #1;
        irq_after = interrupt;
    endtask

    initial begin
        int          n;
        logic        ws;
        logic [3:0]  wen;
        logic        rdy0, rdy, irq, irqa;
        logic [31:0] rd;

        resetn    = 1'b0;
        is_inst   = 1'b0;
        pc_addr   = '0;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[768] = 32'd1;
        mem[769] = 32'd256;
        mem[770] = 32'd512;
        mem[771] = 32'h800;
        mem[772] = 32'hC00;
        mem[10]  = 32'h12345678;
        mem[50]  = 32'h50505050;
        mem[300] = 32'h11111111;
        mem[512] = 32'hA5A5A5A5;

        repeat (3) @(negedge clk);
        chk("rst_wait", 32'(inform_cpu_wait), 32'd1);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_irq", 32'(interrupt), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_cfg0", dut.cfg_q[0], 32'd0);

        resetn = 1'b1;
        wait_load(n, ws);
        chk("load_cycles", 32'(n), 32'd6);
        chk("load_wen", 32'(ws), 32'd0);
        chk("cfg_en", dut.cfg_q[0], 32'd1);
        chk("cfg_dlo", dut.cfg_q[1], 32'd256);
        chk("cfg_dhi", dut.cfg_q[2], 32'd512);
        chk("cfg_tlo", dut.cfg_q[3], 32'h800);
        chk("cfg_thi", dut.cfg_q[4], 32'hC00);

        xfer(22'd10, 32'h0, 4'h0, 1'b0, 32'h40, wen, rdy0, rdy, rd, irq, irqa);
        chk("rd10_ready0", 32'(rdy0), 32'd0);
        chk("rd10_ready", 32'(rdy), 32'd1);
        chk("rd10_data", rd, 32'h12345678);
        chk("rd10_irq", 32'(irq), 32'd0);

        xfer(22'd300, 32'hDEADBEEF, 4'hF, 1'b0, 32'h40,
             wen, rdy0, rdy, rd, irq, irqa);
        chk("st_deny_wen", 32'(wen), 32'd0);
        chk("st_deny_ready", 32'(rdy), 32'd1);
        chk("st_deny_irq", 32'(irq), 32'(IRQ));
        chk("st_deny_irq_end", 32'(irqa), 32'd0);
        chk("st_deny_mem", mem[300], 32'h11111111);

        xfer(22'd300, 32'hDEADBEEF, 4'hF, 1'b0, 32'h900,
             wen, rdy0, rdy, rd, irq, irqa);
        chk("st_trust_wen", 32'(wen), 32'hF);
        chk("st_trust_irq", 32'(irq), 32'd0);
        chk("st_trust_mem", mem[300], 32'hDEADBEEF);

        xfer(22'd300, 32'h0, 4'h0, 1'b1, 32'h40, wen, rdy0, rdy, rd, irq, irqa);
        chk("if_deny_data", rd, 32'd0);
        chk("if_deny_irq", 32'(irq), 32'(IRQ));

        xfer(22'd512, 32'h0, 4'h0, 1'b0, 32'h40, wen, rdy0, rdy, rd, irq, irqa);
        chk("rd_dhi_data", rd, 32'hA5A5A5A5);
        chk("rd_dhi_irq", 32'(irq), 32'd0);

        xfer(22'd770, 32'h0, 4'h0, 1'b0, 32'hC00, wen, rdy0, rdy, rd, irq, irqa);
        chk("rd_cfg_data", rd, 32'd0);
        chk("rd_cfg_irq", 32'(irq), 32'(IRQ));

        xfer(22'd769, 32'h000000FF, 4'h1, 1'b0, 32'h900,
             wen, rdy0, rdy, rd, irq, irqa);
        chk("wt_dlo_reg", dut.cfg_q[1], 32'h1FF);
        chk("wt_dlo_mem", mem[769], 32'h1FF);

        xfer(22'd768, 32'h0, 4'hF, 1'b0, 32'h900, wen, rdy0, rdy, rd, irq, irqa);
        chk("wt_ctrl_reg", dut.cfg_q[0], 32'd0);

        xfer(22'd300, 32'h0, 4'h0, 1'b1, 32'h40, wen, rdy0, rdy, rd, irq, irqa);
        chk("if_off_data", rd, 32'hDEADBEEF);
        chk("if_off_irq", 32'(irq), 32'd0);

        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = 22'd10;
        cpu_wstrb = 4'h0;
        @(posedge clk);
        #1;
        chk("abort_resp", 32'(cpu_ready), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_ready", 32'(cpu_ready), 32'd0);
        chk("abort_wait", 32'(inform_cpu_wait), 32'd1);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        cpu_addr  = 22'd50;
        cpu_wdata = 32'hBAD0BAD0;
        cpu_wstrb = 4'hF;
        @(negedge clk);
        resetn = 1'b1;
        wait_load(n, ws);
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
        chk("reload_cycles", 32'(n), 32'd6);
        chk("reload_wen", 32'(ws), 32'd0);
        chk("reload_en", dut.cfg_q[0], 32'd0);
        chk("reload_dlo", dut.cfg_q[1], 32'h1FF);
        chk("reload_dhi", dut.cfg_q[2], 32'd512);
        repeat (2) @(negedge clk);
        chk("load_valid_ignored", mem[50], 32'h50505050);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

    initial begin
        #100000;
        $fatal(1, "FAIL timeout");
    end

endmodule
